// File: rtl/scan_sel_pkg.sv
// Shared constants, state type and lowest-set-bit helper for the scan
// select sequencer.
package scan_sel_pkg;

   localparam int NUM_CH = 8;
   localparam int SEL_W  = 3;

   typedef enum logic {IDLE, DWELL} scan_state_t;

   // Result of a lowest-set-bit search: index plus "mask was empty" flag.
   typedef struct packed {
      logic [SEL_W-1:0] idx;
      logic             none;
   } low_t;

   // Index of the lowest set bit; idx is 0 and none is 1 for an empty mask.
   function automatic low_t lowest_set(input logic [NUM_CH-1:0] mask);
      low_t r;
      r.idx  = '0;
      r.none = 1'b1;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i]) begin
            r.idx  = SEL_W'(i);
            r.none = 1'b0;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/scan_next_chan.sv
// Combinational next-channel search: finds the next enabled channel strictly
// above cur. When none is above, wrap is set and next falls back to the
// lowest enabled channel of the same mask.
module scan_next_chan
   import scan_sel_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [SEL_W-1:0]  cur,
   output logic [SEL_W-1:0]  next,
   output logic              wrap,
   output logic              none
);

   low_t w_low;
   logic w_hit;

   assign w_low = lowest_set(mask);

   // Scan upward from cur+1; the first set bit found is the next channel.
   always_comb begin
      w_hit = 1'b0;
      next  = w_low.idx;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!w_hit && mask[i] && (SEL_W'(i) > cur)) begin
            next  = SEL_W'(i);
            w_hit = 1'b1;
         end
      end
   end

   assign wrap = !w_hit;
   assign none = w_low.none;

endmodule

// File: rtl/scan_sel_sequencer.sv
// Channel-select sequencer for a downstream 3-to-8 one-hot decoder.
// Sweeps the enabled channels in ascending order, holding each for a
// programmable dwell. Optional sweep counter output enabled by defining
// SCAN_SWEEP_CNT_EN.
// Handshake: no valid/ready pairs; sel is meaningful only while sel_valid=1,
// and sweep_done/mask_err are single-cycle pulses with no back-pressure.
module scan_sel_sequencer
   import scan_sel_pkg::*;
#(
   parameter int DWELL_W = 8,
   parameter int SWEEP_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [NUM_CH-1:0]  chan_en,
   input  logic [DWELL_W-1:0] dwell,
   output logic [SEL_W-1:0]   sel,
   output logic               sel_valid,
   output logic               busy,
   output logic               sweep_done,
`ifdef SCAN_SWEEP_CNT_EN
   output logic [SWEEP_W-1:0] sweep_cnt,
`endif
   output logic               mask_err
);

   scan_state_t        r_state;
   logic [SEL_W-1:0]   r_sel;
   logic [NUM_CH-1:0]  r_mask;
   logic [DWELL_W-1:0] r_dwell;
   logic [DWELL_W-1:0] r_cnt;
   logic               r_sweep_done;
   logic               r_mask_err;

   logic [SEL_W-1:0]   w_next;
   logic               w_wrap;
   logic               w_none;
   logic [DWELL_W-1:0] w_dwell_eff;
   low_t               w_low_in;

   // A dwell of zero behaves exactly like a dwell of one.
   assign w_dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
   assign w_low_in    = lowest_set(chan_en);

   scan_next_chan u_next (
      .mask (r_mask),
      .cur  (r_sel),
      .next (w_next),
      .wrap (w_wrap),
      .none (w_none)
   );

   // Scan state machine: start/stop control, dwell countdown, channel advance
   // and wrap-time resampling of the mask and dwell.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_sel        <= '0;
         r_mask       <= '0;
         r_dwell      <= '0;
         r_cnt        <= '0;
         r_sweep_done <= 1'b0;
         r_mask_err   <= 1'b0;
      end else begin
         r_sweep_done <= 1'b0;
         r_mask_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && !stop) begin
                  if (w_low_in.none) begin
                     r_mask_err <= 1'b1;
                  end else begin
                     r_mask  <= chan_en;
                     r_dwell <= w_dwell_eff;
                     r_sel   <= w_low_in.idx;
                     r_cnt   <= w_dwell_eff - DWELL_W'(1);
                     r_state <= DWELL;
                  end
               end
            end
            DWELL: begin
               if (stop || w_none) begin
                  // sel keeps its last code so the decoder input is stable.
                  r_state <= IDLE;
               end else if (r_cnt != '0) begin
                  r_cnt <= r_cnt - DWELL_W'(1);
               end else if (!w_wrap) begin
                  r_sel <= w_next;
                  r_cnt <= r_dwell - DWELL_W'(1);
               end else begin
                  // End of sweep: the mask and dwell are resampled only here.
                  r_sweep_done <= 1'b1;
                  r_mask       <= chan_en;
                  r_dwell      <= w_dwell_eff;
                  if (w_low_in.none) begin
                     r_mask_err <= 1'b1;
                     r_state    <= IDLE;
                  end else begin
                     r_sel <= w_low_in.idx;
                     r_cnt <= w_dwell_eff - DWELL_W'(1);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef SCAN_SWEEP_CNT_EN
   logic [SWEEP_W-1:0] r_sweep_cnt;

   // Saturating count of completed sweeps, cleared by reset or accepted start.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sweep_cnt <= '0;
      end else if (r_state == IDLE && start && !stop && !w_low_in.none) begin
         r_sweep_cnt <= '0;
      end else if (r_state == DWELL && !stop && !w_none && r_cnt == '0 &&
                   w_wrap && r_sweep_cnt != '1) begin
         r_sweep_cnt <= r_sweep_cnt + SWEEP_W'(1);
      end
   end

   assign sweep_cnt = r_sweep_cnt;
`endif

   assign sel        = r_sel;
   assign sel_valid  = (r_state == DWELL);
   assign busy       = (r_state != IDLE);
   assign sweep_done = r_sweep_done;
   assign mask_err   = r_mask_err;

endmodule
